// File: rtl/core_mc_if.sv
// Instruction-memory request/acknowledge bus between core_mc and its fetch port.
interface core_mc_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/core_mc.sv
// Multi-cycle RV integer core (OP, OP-IMM, LUI) with FETCH/DECODE/EXECUTE/WRITEBACK and a trap-to-HALT.
// Define CORE_MC_INSTRET_EN to add the 64-bit retired-instruction counter output instret.
module core_mc #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  core_mc_if.master        imem,
  output logic             retire,
  output logic             illegal,
  input  logic [4:0]       dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata
`ifdef CORE_MC_INSTRET_EN
  ,
  output logic [63:0]      instret
`endif
);

  localparam int unsigned SHW = (XLEN == 64) ? 6 : 5;
  localparam int unsigned HIW = 12 - SHW;
  localparam logic [HIW-1:0] SRAI_HI = {2'b01, {(HIW - 2){1'b0}}};
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;

  state_t          state, stateNext;
  logic [XLEN-1:0] pc, opA, opB, res, aluRes;
  logic [31:0]     ir;
  logic [XLEN-1:0] regs [32];
  logic            reqQ, legal;

  logic [6:0]       opcode, funct7;
  logic [4:0]       rd, rs1, rs2;
  logic [2:0]       funct3;
  logic [HIW-1:0]   shiftHi;
  logic [SHW-1:0]   shamt;
  logic signed [11:0] immIRaw;
  logic signed [31:0] immURaw;
  logic [XLEN-1:0]  immI, immU;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign shiftHi = ir[31:32-HIW];
  assign immIRaw = ir[31:20];
  assign immURaw = {ir[31:12], 12'b0};
  assign immI    = XLEN'(immIRaw);
  assign immU    = XLEN'(immURaw);
  assign shamt   = opB[SHW-1:0];

  assign imem.imem_req  = reqQ;
  assign imem.imem_addr = pc;
  assign dbg_rdata      = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  // Encoding legality, evaluated on IR during DECODE
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_OP:    legal = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      legal = (shiftHi == '0);
        else if (funct3 == 3'b101) legal = (shiftHi == '0) || (shiftHi == SRAI_HI);
        else                       legal = 1'b1;
      end
      OPC_LUI:   legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  // ALU; ir[30] selects SUB (OP only) and arithmetic right shift (OP and OP-IMM)
  always_comb begin
    aluRes = '0;
    if (opcode == OPC_LUI) begin
      aluRes = opA + opB;
    end else begin
      case (funct3)
        3'b000:  aluRes = ((opcode == OPC_OP) && funct7[5]) ? opA - opB : opA + opB;
        3'b001:  aluRes = opA << shamt;
        3'b010:  aluRes = XLEN'($signed(opA) < $signed(opB));
        3'b011:  aluRes = XLEN'(opA < opB);
        3'b100:  aluRes = opA ^ opB;
        3'b101:  aluRes = funct7[5] ? XLEN'($signed(opA) >>> shamt) : opA >> shamt;
        3'b110:  aluRes = opA | opB;
        default: aluRes = opA & opB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:     if (imem.imem_ack) stateNext = DECODE;
      DECODE:    stateNext = legal ? EXECUTE : HALT;
      EXECUTE:   stateNext = WRITEBACK;
      WRITEBACK: stateNext = FETCH;
      HALT:      stateNext = HALT;
      default:   stateNext = FETCH;
    endcase
  end

  // Datapath latches and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      opA     <= '0;
      opB     <= '0;
      res     <= '0;
      reqQ    <= 1'b1;
      retire  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      reqQ    <= (stateNext == FETCH);
      retire  <= (stateNext == WRITEBACK);
      illegal <= illegal | (stateNext == HALT);
      case (state)
        FETCH:     if (imem.imem_ack) ir <= imem.imem_rdata;
        DECODE: begin
          opA <= (opcode == OPC_LUI) ? '0 : regs[rs1];
          opB <= (opcode == OPC_OP) ? regs[rs2] : ((opcode == OPC_LUI) ? immU : immI);
        end
        EXECUTE:   res <= aluRes;
        WRITEBACK: pc  <= pc + XLEN'(4);
        default:   ;
      endcase
    end
  end

  // Register file; x0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if ((state == WRITEBACK) && (rd != 5'd0)) begin
      regs[rd] <= res;
    end
  end

`ifdef CORE_MC_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     instret <= '0;
    else if (state == WRITEBACK) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_core_mc.sv
// Scoreboard bench for core_mc: an XLEN=64 core (RESET_PC=0x100) and an XLEN=32 core side by side.
module tb_core_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_mc_if #(.XLEN(64)) bus64 ();
  core_mc_if #(.XLEN(32)) bus32 ();

  logic        ret64, ill64, ret32, ill32;
  logic [4:0]  dba64 = 5'd0, dba32 = 5'd0;
  logic [63:0] dbd64;
  logic [31:0] dbd32;
`ifdef CORE_MC_INSTRET_EN
  logic [63:0] instret64, instret32;
`endif

  core_mc #(.XLEN(64), .RESET_PC(64'h100)) dut64 (
    .clk(clk), .rst(rst), .imem(bus64), .retire(ret64), .illegal(ill64),
    .dbg_raddr(dba64), .dbg_rdata(dbd64)
`ifdef CORE_MC_INSTRET_EN
    , .instret(instret64)
`endif
  );

  core_mc #(.XLEN(32), .RESET_PC(32'h0)) dut32 (
    .clk(clk), .rst(rst), .imem(bus32), .retire(ret32), .illegal(ill32),
    .dbg_raddr(dba32), .dbg_rdata(dbd32)
`ifdef CORE_MC_INSTRET_EN
    , .instret(instret32)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m64[32];
  logic [63:0] m32[32];
  logic [63:0] pcExp64, pcExp32;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic reqOf(input bit w);
    return w ? bus32.imem_req : bus64.imem_req;
  endfunction
  function automatic logic [63:0] addrOf(input bit w);
    return w ? {32'h0, bus32.imem_addr} : bus64.imem_addr;
  endfunction
  function automatic logic retOf(input bit w);
    return w ? ret32 : ret64;
  endfunction
  function automatic logic illOf(input bit w);
    return w ? ill32 : ill64;
  endfunction
  function automatic logic [63:0] modelOf(input bit w, input logic [4:0] r);
    return w ? m32[r] : m64[r];
  endfunction
  function automatic logic [63:0] pcOf(input bit w);
    return w ? pcExp32 : pcExp64;
  endfunction

  task automatic setAck(input bit w, input logic a, input logic [31:0] d);
    if (w) begin bus32.imem_ack = a; bus32.imem_rdata = d; end
    else   begin bus64.imem_ack = a; bus64.imem_rdata = d; end
  endtask

  task automatic readReg(input bit w, input logic [4:0] r, output logic [63:0] v);
    if (w) dba32 = r; else dba64 = r;
    #1;
    v = w ? {32'h0, dbd32} : dbd64;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin m64[i] = '0; m32[i] = '0; end
    sb.delete();
    pcExp64 = 64'h100;
    pcExp32 = 64'h0;
  endtask

  // Wait for a request, stall `stall` cycles, then hand over `word`; returns at the DECODE cycle
  task automatic fetchWord(input bit w, input logic [31:0] word, input int stall, output int lat);
    int n;
    logic [63:0] v;
    n = 0;
    while (reqOf(w) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (reqOf(w) !== 1'b1 || addrOf(w) !== pcOf(w)) begin
      errors++;
      $display("FAIL fetch_req: req=%b addr=%h required req=1 addr=%h", reqOf(w), addrOf(w), pcOf(w));
    end
    for (int i = 0; i < stall; i++) begin
      setAck(w, 1'b0, 32'h0);
      @(negedge clk);
      checks++;
      if (reqOf(w) !== 1'b1 || addrOf(w) !== pcOf(w)) begin
        errors++;
        $display("FAIL stall_hold: req=%b addr=%h required req=1 addr=%h", reqOf(w), addrOf(w), pcOf(w));
      end
      readReg(w, word[11:7], v);
      checks++;
      if (v !== modelOf(w, word[11:7])) begin
        errors++;
        $display("FAIL stall_regs: x%0d=%h required %h", word[11:7], v, modelOf(w, word[11:7]));
      end
    end
    setAck(w, 1'b1, word);
    @(negedge clk);
    setAck(w, 1'b0, 32'h0);
    lat = stall + 1;
  endtask

  // Run one legal instruction and score its destination register after writeback
  task automatic runInstr(input bit w, input logic [31:0] word, input int stall,
                          input logic [4:0] rd, input logic [63:0] val);
    int lat, k;
    logic [63:0] v;
    exp_t e;
    sb.push_back(exp_t'{rd, val});
    fetchWord(w, word, stall, lat);
    k = 0;
    while (retOf(w) !== 1'b1 && k < 8) begin @(negedge clk); k++; end
    lat += k;
    checks++;
    if (retOf(w) !== 1'b1 || lat != stall + 3) begin
      errors++;
      $display("FAIL retire_latency: retire=%b cycles=%0d required retire=1 cycles=%0d", retOf(w), lat, stall + 3);
    end
    checks++;
    if (illOf(w) !== 1'b0) begin
      errors++;
      $display("FAIL retire_vs_illegal: illegal=%b required 0", illOf(w));
    end
    @(negedge clk);
    checks++;
    if (retOf(w) !== 1'b0) begin
      errors++;
      $display("FAIL retire_pulse: retire=%b required 0", retOf(w));
    end
    e = sb.pop_front();
    readReg(w, e.rd, v);
    checks++;
    if (v !== e.val) begin
      errors++;
      $display("FAIL reg_x%0d: got %h required %h (word %h)", e.rd, v, e.val, word);
    end
    if (e.rd != 5'd0) begin
      if (w) m32[e.rd] = e.val; else m64[e.rd] = e.val;
    end
    if (w) pcExp32 = (pcExp32 + 64'd4) & 64'hFFFF_FFFF;
    else   pcExp64 = pcExp64 + 64'd4;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1;
    setAck(1'b0, 1'b1, 32'h0000_0013);
    setAck(1'b1, 1'b0, 32'h0);
    clearModel();
    repeat (2) @(negedge clk);
    checks++;
    if (bus64.imem_req !== 1'b1 || bus64.imem_addr !== 64'h100 || ret64 !== 1'b0 || ill64 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h retire=%b illegal=%b required 1/100/0/0",
               bus64.imem_req, bus64.imem_addr, ret64, ill64);
    end
    readReg(1'b0, 5'd1, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL reset_regs: x1=%h required 0", v); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus64.imem_addr !== 64'h100) begin
      errors++;
      $display("FAIL release_addr: addr=%h required 100", bus64.imem_addr);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (ret64 !== (c == 3)) begin
        errors++;
        $display("FAIL first_retire: cycle %0d retire=%b required %b", c + 1, ret64, (c == 3));
      end
    end
    setAck(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus64.imem_req !== 1'b1 || bus64.imem_addr !== 64'h104) begin
      errors++;
      $display("FAIL next_fetch: req=%b addr=%h required 1/104", bus64.imem_req, bus64.imem_addr);
    end
    pcExp64 = 64'h104;
  endtask

  task automatic test_imm_shift();
    runInstr(1'b0, 32'hFFF0_0093, 0, 5'd1, ONES);
    runInstr(1'b0, encI(12'h03C, 5'd1, 3'b101, 5'd2), 0, 5'd2, 64'hF);
    runInstr(1'b0, encI(12'h43C, 5'd1, 3'b101, 5'd3), 0, 5'd3, ONES);
    runInstr(1'b0, encI(12'h03F, 5'd2, 3'b001, 5'd12), 0, 5'd12, 64'h8000_0000_0000_0000);
    runInstr(1'b0, encI(12'h001, 5'd1, 3'b000, 5'd13), 0, 5'd13, 64'h0);
  endtask

  task automatic test_alu_op();
    runInstr(1'b0, encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd5), 0, 5'd5, 64'hE);
    runInstr(1'b0, encR(7'h20, 5'd1, 5'd2, 3'b000, 5'd6), 0, 5'd6, 64'h10);
    runInstr(1'b0, encR(7'h00, 5'd1, 5'd2, 3'b011, 5'd7), 0, 5'd7, 64'h1);
    runInstr(1'b0, encR(7'h00, 5'd1, 5'd2, 3'b010, 5'd8), 0, 5'd8, 64'h0);
    runInstr(1'b0, encR(7'h00, 5'd2, 5'd1, 3'b100, 5'd9), 0, 5'd9, 64'hFFFF_FFFF_FFFF_FFF0);
    runInstr(1'b0, encR(7'h20, 5'd2, 5'd1, 3'b101, 5'd10), 0, 5'd10, ONES);
    runInstr(1'b0, encR(7'h00, 5'd2, 5'd1, 3'b101, 5'd11), 0, 5'd11, 64'h0001_FFFF_FFFF_FFFF);
  endtask

  task automatic test_x0();
    runInstr(1'b0, 32'h0050_0013, 0, 5'd0, 64'h0);
  endtask

  task automatic test_back_to_back();
    runInstr(1'b0, encI(12'h007, 5'd0, 3'b000, 5'd4), 3, 5'd4, 64'h7);
    runInstr(1'b0, encI(12'h001, 5'd4, 3'b000, 5'd4), 1, 5'd4, 64'h8);
  endtask

  task automatic test_illegal(input logic [31:0] word);
    int lat;
    logic [63:0] v;
    fetchWord(1'b0, word, 0, lat);
    @(negedge clk);
    checks++;
    if (ill64 !== 1'b1 || bus64.imem_req !== 1'b0 || ret64 !== 1'b0) begin
      errors++;
      $display("FAIL illegal_halt: word=%h illegal=%b req=%b retire=%b required 1/0/0",
               word, ill64, bus64.imem_req, ret64);
    end
    setAck(1'b0, 1'b1, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus64.imem_req !== 1'b0 || ret64 !== 1'b0 || ill64 !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold: req=%b retire=%b illegal=%b required 0/0/1", bus64.imem_req, ret64, ill64);
      end
    end
    setAck(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (ill64 !== 1'b0 || bus64.imem_req !== 1'b1 || bus64.imem_addr !== 64'h100) begin
      errors++;
      $display("FAIL halt_reset: illegal=%b req=%b addr=%h required 0/1/100", ill64, bus64.imem_req, bus64.imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    readReg(1'b0, 5'd1, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL halt_reset_regs: x1=%h required 0", v); end
    runInstr(1'b0, encI(12'h003, 5'd0, 3'b000, 5'd1), 0, 5'd1, 64'h3);
  endtask

  task automatic test_xlen32();
    int lat;
    runInstr(1'b1, {20'h80000, 5'd5, 7'b0110111}, 0, 5'd5, 64'h8000_0000);
    runInstr(1'b1, encR(7'h00, 5'd0, 5'd5, 3'b010, 5'd6), 1, 5'd6, 64'h1);
`ifdef CORE_MC_INSTRET_EN
    checks++;
    if (instret32 !== 64'd2) begin errors++; $display("FAIL instret: got %0d required 2", instret32); end
`endif
    fetchWord(1'b1, encI(12'h020, 5'd5, 3'b001, 5'd7), 0, lat);
    @(negedge clk);
    checks++;
    if (ill32 !== 1'b1 || bus32.imem_req !== 1'b0 || ret32 !== 1'b0) begin
      errors++;
      $display("FAIL slli32_illegal: illegal=%b req=%b retire=%b required 1/0/0", ill32, bus32.imem_req, ret32);
    end
`ifdef CORE_MC_INSTRET_EN
    repeat (2) @(negedge clk);
    checks++;
    if (instret32 !== 64'd2) begin errors++; $display("FAIL instret_halt: got %0d required 2", instret32); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_imm_shift();
    test_alu_op();
    test_x0();
    test_back_to_back();
    test_illegal(32'h0000_0000);
    test_illegal(encR(7'h20, 5'd2, 5'd1, 3'b001, 5'd5));
    test_illegal(encI(12'h401, 5'd1, 3'b001, 5'd5));
    test_xlen32();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
